tmr_checker_scrubber: RTL and testbench
=======================================

Name: tmr_checker_scrubber

Overview:
Receiving end of the triple-modular-redundant datapath. It takes the three replica results (R1/R2/R3 lanes) from the cascaded adder pipelines and produces a registered bitwise-majority result. It identifies the disagreeing lane and drives a scrub request/acknowledge handshake back to the replicas so the faulty lane can be resynchronised. When it reaches an uncorrectable or persistent fault, it raises the sticky alarm Err_out_Final.

Parameters:
WORD_WIDTH, 8, bit width of each replica word and the voted output
ACK_TIMEOUT, 16, cycles allowed in SCRUB waiting for scrub_ack before declaring failure
MAX_RETRY, 3, consecutive scrubs of the same lane tolerated before declaring failure
CNT_WIDTH, 8, width of the saturating corrected-error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_1  input  WORD_WIDTH  replica R1 result
in_2  input  WORD_WIDTH  replica R2 result
in_3  input  WORD_WIDTH  replica R3 result
valid_in  input  1  replica words valid this cycle
sum  output  WORD_WIDTH  registered voted result
valid_out  output  1  sum valid (1-cycle delayed valid_in)
scrub_req  output  1  request resync of lane scrub_lane
scrub_lane  output  2  faulty lane: 1=R1, 2=R2, 3=R3, 0=none
scrub_ack  input  1  replicas confirm scrub completed
err_count  output  CNT_WIDTH  corrected single-lane mismatches, saturating
Err_out_Final  output  1  sticky alarm

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). All outputs are 0 during and after reset; the FSM enters IDLE and the retry counter is 0.
- Vote: sum <= (in_1&in_2)|(in_2&in_3)|(in_1&in_3), registered whenever valid_in=1, so latency is 1 cycle. sum holds its value when valid_in=0. valid_out <= valid_in.
- Classification, word-level, only when valid_in=1:
  - all three equal: clean.
  - exactly one lane differs from the other two: single fault, faulty lane = the odd one.
  - all three pairwise distinct: uncorrectable.
- Voting and valid_out continue in every FSM state. Mismatches are classified in all states except FAIL.
- err_count increments by 1 per single-fault word and saturates at all-ones. It does not wrap.
- FSM:
  - IDLE:
    - single fault -> SCRUB, latch scrub_lane.
    - uncorrectable -> FAIL.
    - clean -> clear retry counter.
  - SCRUB:
    - scrub_req=1, scrub_lane stable. The timeout counter runs from 0.
    - scrub_ack=1 -> CHECK, increment retry counter.
    - ACK_TIMEOUT cycles without ack -> FAIL.
    - An uncorrectable word -> FAIL, which has priority over ack in the same cycle.
    - Further single faults still count in err_count but do not change scrub_lane.
  - CHECK: scrub_req=0; wait for the next valid_in word.
    - clean -> IDLE, clear retry counter.
    - single fault, same lane, retry counter >= MAX_RETRY -> FAIL.
    - single fault, same lane, retry counter below MAX_RETRY -> SCRUB.
    - single fault, different lane -> SCRUB with the new lane, retry counter reset to 0.
    - uncorrectable -> FAIL.
  - FAIL: Err_out_Final=1, scrub_req=0, scrub_lane=0. Leaves only on rst.
- scrub_ack outside SCRUB is ignored.
- Err_out_Final is registered and asserted the cycle after the FSM enters FAIL.
- Reset mid-scrub: scrub_req drops to 0 immediately (asynchronously). Counters and alarm clear.

Decomposition:
- Shared package: FSM state encoding (IDLE/SCRUB/CHECK/FAIL), lane codes (LANE_NONE=0, LANE_R1..R3), and the classification enum (CLEAN/SINGLE/UNCORR).
- One natural sub-module: tmr_classify. It is combinational and takes three words to produce the voted word, the class, and the faulty lane. It reuses the same majority equation as the existing voter.

Test Plan:
1. in_1=in_2=in_3=8'h5A, valid_in=1 for 4 cycles -> sum=8'h5A one cycle after each word; valid_out follows valid_in delayed by 1; scrub_req=0; err_count=0; Err_out_Final=0.
2. in_2=8'h5B, others 8'h5A -> sum=8'h5A, err_count=1, scrub_req=1 with scrub_lane=2. Ack after 3 cycles, then a clean word -> IDLE with scrub_req=0.
3. in_3=8'h00 persistently while acking every scrub (MAX_RETRY=3) -> after 3 scrub/ack rounds the next faulty word gives FAIL and Err_out_Final=1 on the following cycle.
4. in_1=8'h01, in_2=8'h02, in_3=8'h04 -> sum=8'h00, Err_out_Final=1, no scrub_req. The alarm holds after clean words resume and clears only on rst.
5. Single fault on lane 1 with scrub_ack never asserted -> scrub_req high for exactly 16 cycles, then FAIL and Err_out_Final=1.
6. Assert rst mid-SCRUB with err_count=5 -> scrub_req, err_count, sum, and Err_out_Final all 0 immediately. A clean operation after release behaves as in scenario 1.

Source files
------------

// File: rtl/tmr_checker_scrubber_pkg.sv
// tmr_checker_scrubber_pkg: shared FSM states, lane codes and vote classes
package tmr_checker_scrubber_pkg;
    typedef enum logic [1:0] {IDLE, SCRUB, CHECK, FAIL} state_t;
    typedef enum logic [1:0] {CLEAN, SINGLE, UNCORR} cls_t;
    localparam logic [1:0] LANE_NONE = 2'd0, LANE_R1 = 2'd1, LANE_R2 = 2'd2, LANE_R3 = 2'd3;
endpackage

// File: rtl/tmr_classify.sv
// tmr_classify: bitwise majority vote plus word-level agreement class and odd lane
module tmr_classify import tmr_checker_scrubber_pkg::*; #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    input  logic [WORD_WIDTH-1:0] c,
    output logic [WORD_WIDTH-1:0] vote,
    output cls_t                  cls,
    output logic [1:0]            lane
);
    logic eq_ab, eq_bc, eq_ac;
    assign eq_ab = a == b;
    assign eq_bc = b == c;
    assign eq_ac = a == c;
    assign vote  = (a & b) | (b & c) | (a & c);
    assign cls   = (eq_ab && eq_bc) ? CLEAN : (eq_ab || eq_bc || eq_ac) ? SINGLE : UNCORR;
    // the lane left out of the one agreeing pair is the faulty one
    assign lane  = cls != SINGLE ? LANE_NONE : eq_bc ? LANE_R1 : eq_ac ? LANE_R2 : LANE_R3;
endmodule

// File: rtl/tmr_checker_scrubber.sv
// tmr_checker_scrubber: registered TMR vote with lane scrub handshake and sticky alarm
module tmr_checker_scrubber import tmr_checker_scrubber_pkg::*; #(
    parameter int WORD_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_1,
    input  logic [WORD_WIDTH-1:0] in_2,
    input  logic [WORD_WIDTH-1:0] in_3,
    input  logic                  valid_in,
    output logic [WORD_WIDTH-1:0] sum,
    output logic                  valid_out,
    output logic                  scrub_req,
    output logic [1:0]            scrub_lane,
    input  logic                  scrub_ack,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  Err_out_Final
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    state_t state, state_n;
    cls_t cls;
    logic [WORD_WIDTH-1:0] vote;
    logic [1:0] fault_lane, lane, lane_n;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] retry, retry_n;
    logic clean, single, uncorr;

    tmr_classify #(.WORD_WIDTH(WORD_WIDTH)) u_classify (
        .a(in_1), .b(in_2), .c(in_3), .vote(vote), .cls(cls), .lane(fault_lane)
    );

    assign clean      = valid_in && state != FAIL && cls == CLEAN;
    assign single     = valid_in && state != FAIL && cls == SINGLE;
    assign uncorr     = valid_in && state != FAIL && cls == UNCORR;
    assign scrub_req  = state == SCRUB;
    assign scrub_lane = scrub_req ? lane : LANE_NONE;

    always_comb begin
        state_n = state;
        lane_n  = lane;
        retry_n = retry;
        case (state)
            IDLE: begin
                if (single) begin
                    state_n = SCRUB;
                    lane_n  = fault_lane;
                end else if (uncorr) state_n = FAIL;
                else if (clean) retry_n = '0;
            end
            SCRUB: begin
                if (uncorr) state_n = FAIL;
                else if (scrub_ack) begin
                    state_n = CHECK;
                    retry_n = retry + 1'b1;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) state_n = FAIL;
            end
            CHECK: begin
                if (clean) begin
                    state_n = IDLE;
                    retry_n = '0;
                end else if (uncorr) state_n = FAIL;
                else if (single && fault_lane != lane) begin
                    state_n = SCRUB;
                    lane_n  = fault_lane;
                    retry_n = '0;
                end else if (single) state_n = retry >= RW'(MAX_RETRY) ? FAIL : SCRUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lane          <= LANE_NONE;
            retry         <= '0;
            tcnt          <= '0;
            sum           <= '0;
            valid_out     <= 1'b0;
            err_count     <= '0;
            Err_out_Final <= 1'b0;
        end else begin
            state         <= state_n;
            lane          <= lane_n;
            retry         <= retry_n;
            tcnt          <= (state == SCRUB && state_n == SCRUB) ? tcnt + 1'b1 : '0;
            valid_out     <= valid_in;
            Err_out_Final <= state == FAIL;
            if (valid_in) sum <= vote;
            if (single && ~&err_count) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_tmr_checker_scrubber.sv
// tb_tmr_checker_scrubber: table vectors, corner sequences and a random run against a reference model
module tb_tmr_checker_scrubber;
    localparam int ACK_TIMEOUT = 16;
    localparam int MAX_RETRY   = 3;
    typedef enum {M_IDLE, M_SCRUB, M_CHECK, M_FAIL} mode_t;
    typedef struct {
        logic [7:0] a, b, c;
        logic       v, ack;
        logic [7:0] sum;
        logic       vo, req;
        logic [1:0] lane;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] in_1 = '0, in_2 = '0, in_3 = '0, sum, err_count;
    logic valid_in = 1'b0, scrub_ack = 1'b0, valid_out, scrub_req, Err_out_Final;
    logic [1:0] scrub_lane;
    int vecs = 0, errs = 0;

    mode_t m_st;
    int m_lane, m_retry, m_wait, m_cnt;
    logic [7:0] m_sum;
    logic m_vo, m_err;
    vec_t tbl[$];

    always #5 clk = ~clk;

    tmr_checker_scrubber dut (
        .clk(clk), .rst(rst), .in_1(in_1), .in_2(in_2), .in_3(in_3), .valid_in(valid_in),
        .sum(sum), .valid_out(valid_out), .scrub_req(scrub_req), .scrub_lane(scrub_lane),
        .scrub_ack(scrub_ack), .err_count(err_count), .Err_out_Final(Err_out_Final)
    );

    function automatic logic [7:0] maj(input logic [7:0] a, b, c);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        return r;
    endfunction

    // number of distinct words: 1 clean, 2 single fault, 3 uncorrectable
    function automatic int kind(input logic [7:0] a, b, c);
        return 1 + int'(b != a) + int'(c != a && c != b);
    endfunction

    function automatic int odd(input logic [7:0] a, b, c);
        return a == b ? 3 : a == c ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_lane = 0; m_retry = 0; m_wait = 0; m_cnt = 0;
        m_sum = '0; m_vo = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] a, b, c, input logic v, ack);
        int k, l;
        k = kind(a, b, c);
        l = odd(a, b, c);
        m_err = m_err | (m_st == M_FAIL);
        m_vo = v;
        if (v) m_sum = maj(a, b, c);
        if (m_st != M_FAIL && v && k == 2 && m_cnt < 255) m_cnt++;
        case (m_st)
            M_IDLE: if (v) begin
                if (k == 2) begin m_st = M_SCRUB; m_lane = l; m_wait = 0; end
                else if (k == 3) m_st = M_FAIL;
                else m_retry = 0;
            end
            M_SCRUB: begin
                m_wait++;
                if (v && k == 3) m_st = M_FAIL;
                else if (ack) begin m_st = M_CHECK; m_retry++; end
                else if (m_wait >= ACK_TIMEOUT) m_st = M_FAIL;
            end
            M_CHECK: if (v) begin
                if (k == 1) begin m_st = M_IDLE; m_retry = 0; end
                else if (k == 3) m_st = M_FAIL;
                else if (l != m_lane) begin m_st = M_SCRUB; m_lane = l; m_retry = 0; m_wait = 0; end
                else if (m_retry >= MAX_RETRY) m_st = M_FAIL;
                else begin m_st = M_SCRUB; m_wait = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("sum", 32'(sum), 32'(m_sum));
        chk("valid_out", 32'(valid_out), 32'(m_vo));
        chk("scrub_req", 32'(scrub_req), 32'(m_st == M_SCRUB));
        chk("scrub_lane", 32'(scrub_lane), m_st == M_SCRUB ? m_lane : 0);
        chk("err_count", 32'(err_count), m_cnt);
        chk("alarm", 32'(Err_out_Final), 32'(m_err));
    endtask

    task automatic apply(input logic [7:0] a, b, c, input logic v, ack);
        in_1 = a; in_2 = b; in_3 = c; valid_in = v; scrub_ack = ack;
        @(posedge clk);
        model_step(a, b, c, v, ack);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_1 = '0; in_2 = '0; in_3 = '0; valid_in = 1'b0; scrub_ack = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi;
        tbl.push_back('{8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0});
        tbl.push_back('{8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0});
        tbl.push_back('{8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0});
        tbl.push_back('{8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0});
        tbl.push_back('{8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0});
        tbl.push_back('{8'h5A, 8'h5B, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 2'd2, 8'd1, 1'b0});
        tbl.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 2'd2, 8'd1, 1'b0});
        tbl.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 2'd2, 8'd1, 1'b0});
        tbl.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0});
        tbl.push_back('{8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'd1, 1'b0});
        tbl.push_back('{8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 2'd0, 8'd1, 1'b0});
        tbl.push_back('{8'h01, 8'h02, 8'h04, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'd1, 1'b0});
        tbl.push_back('{8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'd1, 1'b1});
        tbl.push_back('{8'h5A, 8'h5A, 8'h5B, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 2'd0, 8'd1, 1'b1});
        tbl.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 2'd0, 8'd1, 1'b1});

        do_reset();
        chk("reset_sum", 32'(sum), 0);
        chk("reset_req", 32'(scrub_req), 0);
        chk("reset_cnt", 32'(err_count), 0);
        chk("reset_alarm", 32'(Err_out_Final), 0);
        chk("reset_valid_out", 32'(valid_out), 0);

        foreach (tbl[i]) begin
            apply(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].v, tbl[i].ack);
            chk($sformatf("row%0d_sum", i), 32'(sum), 32'(tbl[i].sum));
            chk($sformatf("row%0d_valid_out", i), 32'(valid_out), 32'(tbl[i].vo));
            chk($sformatf("row%0d_req", i), 32'(scrub_req), 32'(tbl[i].req));
            chk($sformatf("row%0d_lane", i), 32'(scrub_lane), 32'(tbl[i].lane));
            chk($sformatf("row%0d_cnt", i), 32'(err_count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d_alarm", i), 32'(Err_out_Final), 32'(tbl[i].err));
        end

        // persistent lane-3 fault acked every time: fourth faulty word fails
        do_reset();
        for (int r = 0; r < 3; r++) begin
            apply(8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0);
            chk_model();
            chk("retry_req", 32'(scrub_req), 1);
            chk("retry_lane", 32'(scrub_lane), 3);
            apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
            chk_model();
        end
        apply(8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0);
        chk_model();
        chk("retry_fail_req", 32'(scrub_req), 0);
        chk("retry_fail_alarm_early", 32'(Err_out_Final), 0);
        apply(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
        chk("retry_fail_alarm", 32'(Err_out_Final), 1);
        chk("retry_cnt", 32'(err_count), 4);

        // ack never arrives: request stays up exactly ACK_TIMEOUT cycles
        do_reset();
        apply(8'h5B, 8'h5A, 8'h5A, 1'b1, 1'b0);
        chk("timeout_lane", 32'(scrub_lane), 1);
        hi = 0;
        for (int i = 0; i < 40 && scrub_req; i++) begin
            hi++;
            apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        chk("timeout_req_cycles", hi, ACK_TIMEOUT);
        apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("timeout_alarm", 32'(Err_out_Final), 1);

        // asynchronous reset in the middle of a scrub
        do_reset();
        for (int i = 0; i < 5; i++) apply(8'h5B, 8'h5A, 8'h5A, 1'b1, 1'b0);
        chk("mid_cnt", 32'(err_count), 5);
        chk("mid_req", 32'(scrub_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", 32'(scrub_req), 0);
        chk("async_cnt", 32'(err_count), 0);
        chk("async_sum", 32'(sum), 0);
        chk("async_alarm", 32'(Err_out_Final), 0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
            chk("post_reset_sum", 32'(sum), 32'h5A);
            chk_model();
        end

        // rotating lanes with acks never trip retry limit, so err_count saturates
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [7:0] w[3];
            w = '{8'h33, 8'h33, 8'h33};
            w[i % 3] = 8'hCC;
            apply(w[0], w[1], w[2], 1'b1, 1'b1);
            chk_model();
        end
        chk("saturate_cnt", 32'(err_count), 255);
        chk("saturate_alarm", 32'(Err_out_Final), 0);

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] base;
            logic [7:0] w[3];
            int r;
            if (n % 250 == 0) do_reset();
            base = 8'($urandom);
            w = '{base, base, base};
            r = $urandom_range(0, 99);
            if (r == 0) begin
                w[1] = base ^ 8'h01;
                w[2] = base ^ 8'h02;
            end else if (r < 25) w[$urandom_range(0, 2)] = base ^ (8'h01 << $urandom_range(0, 7));
            apply(w[0], w[1], w[2], $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0);
            chk_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
